// File: rtl/hxm_list_sequencer_pkg.sv
// Shared types and constants for the hxmpp list sequencer.
// Holds the FSM state encoding, the mode bit positions and the default data widths.
package hxm_list_sequencer_pkg;

    localparam int HXM_SSID_BITS    = 8;
    localparam int HXM_HITINFO_BITS = 8;

    localparam int MODE_RST = 0;
    localparam int MODE_WR  = 1;
    localparam int MODE_RD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HRST  = 3'd1,
        ST_WRITE = 3'd2,
        ST_GAP   = 3'd3,
        ST_READ  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_e;

endpackage

// File: rtl/hxm_seq_list_ram.sv
// List storage: one write port, two registered read ports (issue and compare).
// Reads in the same cycle as a write to the same address return the new data.
module hxm_seq_list_ram #(
    parameter int DW    = 17,
    parameter int BW    = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [BW-1:0] rb_data
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] ra_data_q, ra_data_d;
    logic [BW-1:0] rb_data_q, rb_data_d;

    always_comb begin
        ra_data_d = mem_q[ra_addr];
        rb_data_d = mem_q[rb_addr][BW-1:0];
        if (we && (waddr == ra_addr)) ra_data_d = wdata;
        if (we && (waddr == rb_addr)) rb_data_d = wdata[BW-1:0];
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        ra_data_q <= ra_data_d;
        rb_data_q <= rb_data_d;
    end

    assign ra_data = ra_data_q;
    assign rb_data = rb_data_q;

endmodule

// File: rtl/hxm_list_sequencer.sv
// Stimulus/check engine for hxmpp: replays a loaded list as writes, reads it back
// and compares the returned data against the list.
module hxm_list_sequencer
    import hxm_list_sequencer_pkg::*;
#(
    parameter int SSID_BITS    = HXM_SSID_BITS,
    parameter int HITINFO_BITS = HXM_HITINFO_BITS,
    parameter int DEPTH        = 32,
    parameter int IDX_BITS     = 5,
    parameter int READ_LATENCY = 2,
    parameter int RESET_CYCLES = 2,
    parameter int GAP_CYCLES   = 4,
    parameter int ERR_BITS     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic [IDX_BITS-1:0]     load_idx,
    input  logic [SSID_BITS-1:0]    load_ssid,
    input  logic [HITINFO_BITS-1:0] load_hitinfo,
    input  logic                    load_chk,
    input  logic                    start,
    input  logic [2:0]              mode,
    input  logic [IDX_BITS:0]       n_entries,
    input  logic                    abort,
    output logic                    hxm_reset,
    output logic                    write,
    output logic [SSID_BITS-1:0]    writeSSID,
    output logic [HITINFO_BITS-1:0] writeHitInfo,
    output logic                    read,
    output logic [SSID_BITS-1:0]    readSSID,
    input  logic [SSID_BITS-1:0]    SSID_read,
    input  logic [HITINFO_BITS-1:0] hitInfo_read,
    output logic                    busy,
    output logic                    done,
    output logic [ERR_BITS-1:0]     err_count,
    output logic                    first_err_valid,
    output logic [IDX_BITS-1:0]     first_err_idx
);

    localparam int BW = SSID_BITS + HITINFO_BITS;
    localparam int EW = 1 + BW;
    localparam int CW = 16;
    localparam int RL = READ_LATENCY;

    localparam logic [IDX_BITS:0] N_MAX    = (IDX_BITS+1)'(DEPTH);
    localparam logic [CW-1:0]     RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0]     DRN_LAST = CW'(RL - 1);

    typedef struct packed {
        logic                vld;
        logic                chk;
        logic [IDX_BITS-1:0] idx;
    } cmp_t;

    seq_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [IDX_BITS:0]   n_q, n_d;
    cmp_t                pipe_q [RL];
    cmp_t                pipe_d [RL];
    logic [ERR_BITS-1:0] err_q, err_d;
    logic                fev_q, fev_d;
    logic [IDX_BITS-1:0] fei_q, fei_d;

    logic                    idle;
    logic                    go;
    logic [IDX_BITS:0]       n_clamp;
    logic [EW-1:0]           ra_data;
    logic [BW-1:0]           rb_data;
    logic                    a_chk;
    logic [SSID_BITS-1:0]    a_ssid;
    logic [HITINFO_BITS-1:0] a_hit;
    logic [SSID_BITS-1:0]    b_ssid;
    logic [HITINFO_BITS-1:0] b_hit;
    logic                    last_ent;
    cmp_t                    co;
    logic                    miss;

    assign idle    = (state_q == ST_IDLE);
    assign go      = idle && start && !abort;
    assign n_clamp = (n_entries > N_MAX) ? N_MAX : n_entries;

    hxm_seq_list_ram #(
        .DW    (EW),
        .BW    (BW),
        .DEPTH (DEPTH),
        .AW    (IDX_BITS)
    ) u_ram (
        .clk     (clk),
        .we      (idle && load_en),
        .waddr   (load_idx),
        .wdata   ({load_chk, load_ssid, load_hitinfo}),
        .ra_addr (cnt_d[IDX_BITS-1:0]),
        .ra_data (ra_data),
        .rb_addr (pipe_d[RL-1].idx),
        .rb_data (rb_data)
    );

    assign a_chk  = ra_data[EW-1];
    assign a_ssid = ra_data[BW-1 -: SSID_BITS];
    assign a_hit  = ra_data[HITINFO_BITS-1:0];
    assign b_ssid = rb_data[BW-1 -: SSID_BITS];
    assign b_hit  = rb_data[HITINFO_BITS-1:0];

    assign last_ent = (cnt_q == CW'(n_q) - CW'(1));

    function automatic seq_state_e pick(input logic r, input logic w, input logic rd);
        if (r)       return ST_HRST;
        else if (w)  return ST_WRITE;
        else if (rd) return ST_READ;
        else         return ST_DONE;
    endfunction

    // The counter doubles as the list index, so cnt_d prefetches the next entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        wr_en_d = wr_en_q;
        rd_en_d = rd_en_q;
        n_d     = n_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (start) begin
                        n_d     = n_clamp;
                        wr_en_d = mode[MODE_WR] && (n_clamp != '0);
                        rd_en_d = mode[MODE_RD] && (n_clamp != '0);
                        state_d = pick(mode[MODE_RST], wr_en_d, rd_en_d);
                    end
                end
                ST_HRST: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_d   = '0;
                        state_d = pick(1'b0, wr_en_q, rd_en_q);
                    end
                end
                ST_WRITE: begin
                    if (last_ent) begin
                        cnt_d = '0;
                        if (!rd_en_q)          state_d = ST_DONE;
                        else if (GAP_CYCLES > 0) state_d = ST_GAP;
                        else                   state_d = ST_READ;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (last_ent) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == DRN_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pipe_d[0].vld = (state_q == ST_READ) && !abort;
        pipe_d[0].chk = a_chk && !abort;
        pipe_d[0].idx = abort ? '0 : cnt_q[IDX_BITS-1:0];
        for (int i = 1; i < RL; i++) begin
            pipe_d[i] = abort ? '0 : pipe_q[i-1];
        end
    end

    assign co   = pipe_q[RL-1];
    assign miss = co.vld && co.chk &&
                  ((SSID_read != b_ssid) || (hitInfo_read != b_hit));

    always_comb begin
        err_d = err_q;
        fev_d = fev_q;
        fei_d = fei_q;
        if (go) begin
            err_d = '0;
            fev_d = 1'b0;
            fei_d = '0;
        end else if (miss) begin
            if (err_q != '1) err_d = err_q + ERR_BITS'(1);
            if (!fev_q) begin
                fev_d = 1'b1;
                fei_d = co.idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            n_q     <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fei_q   <= '0;
            for (int i = 0; i < RL; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            n_q     <= n_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fei_q   <= fei_d;
            for (int i = 0; i < RL; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign hxm_reset       = (state_q == ST_HRST);
    assign write           = (state_q == ST_WRITE);
    assign writeSSID       = write ? a_ssid : '0;
    assign writeHitInfo    = write ? a_hit : '0;
    assign read            = (state_q == ST_READ);
    assign readSSID        = read ? a_ssid : '0;
    assign busy            = !idle;
    assign done            = (state_q == ST_DONE);
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_hxm_list_sequencer.sv
// Directed bench for hxm_list_sequencer with a behavioural two-cycle hxmpp model.
// Error width is narrowed so counter saturation is reachable within one list.
module tb_hxm_list_sequencer;

    localparam int SB = 8;
    localparam int HB = 8;
    localparam int DEPTH = 32;
    localparam int IB = 5;
    localparam int EB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_en = 1'b0;
    logic [IB-1:0] load_idx = '0;
    logic [SB-1:0] load_ssid = '0;
    logic [HB-1:0] load_hitinfo = '0;
    logic          load_chk = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    mode = '0;
    logic [IB:0]   n_entries = '0;
    logic          abort = 1'b0;
    logic          hxm_reset, write, read, busy, done;
    logic [SB-1:0] writeSSID, readSSID, SSID_read;
    logic [HB-1:0] writeHitInfo, hitInfo_read;
    logic [EB-1:0] err_count;
    logic          first_err_valid;
    logic [IB-1:0] first_err_idx;

    hxm_list_sequencer #(
        .SSID_BITS(SB), .HITINFO_BITS(HB), .DEPTH(DEPTH), .IDX_BITS(IB),
        .READ_LATENCY(2), .RESET_CYCLES(2), .GAP_CYCLES(4), .ERR_BITS(EB)
    ) dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_idx(load_idx), .load_ssid(load_ssid),
        .load_hitinfo(load_hitinfo), .load_chk(load_chk),
        .start(start), .mode(mode), .n_entries(n_entries), .abort(abort),
        .hxm_reset(hxm_reset), .write(write), .writeSSID(writeSSID),
        .writeHitInfo(writeHitInfo), .read(read), .readSSID(readSSID),
        .SSID_read(SSID_read), .hitInfo_read(hitInfo_read),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // hxmpp model: memory indexed by SSID, two-cycle read, optional corruption
    logic [HB-1:0] mmem [256];
    logic          corrupt [256];
    logic [SB-1:0] s1, s2;
    logic [HB-1:0] h1, h2;
    initial begin
        for (int i = 0; i < 256; i++) begin
            mmem[i] = '0;
            corrupt[i] = 1'b0;
        end
    end
    always @(posedge clk) begin
        if (write) mmem[writeSSID] <= writeHitInfo;
        s1 <= readSSID;
        h1 <= mmem[readSSID] ^ (corrupt[readSSID] ? 8'hFF : 8'h00);
        s2 <= s1;
        h2 <= h1;
    end
    assign SSID_read = s2;
    assign hitInfo_read = h2;

    logic [SB-1:0] ex_ssid [DEPTH];
    logic [HB-1:0] ex_hit [DEPTH];

    int wr_cnt, rd_cnt, hr_cnt, done_cnt, wr_bad, rd_bad;
    int first_wr, last_wr, first_rd, last_rd, done_cyc, s_cyc;

    always @(negedge clk) begin
        if (write) begin
            if (wr_cnt < DEPTH &&
                (writeSSID !== ex_ssid[wr_cnt] || writeHitInfo !== ex_hit[wr_cnt]))
                wr_bad++;
            if (wr_cnt > 0 && cyc != last_wr + 1) wr_bad++;
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
        end
        if (read) begin
            if (rd_cnt < DEPTH && readSSID !== ex_ssid[rd_cnt]) rd_bad++;
            if (rd_cnt > 0 && cyc != last_rd + 1) rd_bad++;
            if (rd_cnt == 0) first_rd = cyc;
            last_rd = cyc;
            rd_cnt++;
        end
        if (hxm_reset) hr_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        wr_cnt = 0; rd_cnt = 0; hr_cnt = 0; done_cnt = 0;
        wr_bad = 0; rd_bad = 0; done_cyc = -1;
        first_wr = -1; last_wr = -1; first_rd = -1; last_rd = -1;
    endtask

    task automatic load(input int idx, input logic [7:0] s, input logic c);
        load_en = 1'b1;
        load_idx = IB'(idx);
        load_ssid = s;
        load_hitinfo = s;
        load_chk = c;
        ex_ssid[idx] = s;
        ex_hit[idx] = s;
        step();
        load_en = 1'b0;
    endtask

    task automatic go(input logic [2:0] m, input logic [IB:0] n);
        clr();
        s_cyc = cyc;
        mode = m;
        n_entries = n;
        start = 1'b1;
        step();
        start = 1'b0;
        load_en = 1'b0;
        for (int i = 0; i < 300 && done_cnt == 0; i++) step();
        if (done_cnt == 0) check("done_timeout", 0, 1);
        step();
        step();
    endtask

    task automatic run_full(input string t);
        go(3'b111, 6'd23);
        check({t, "_hr"}, hr_cnt, 2);
        check({t, "_wr_n"}, wr_cnt, 23);
        check({t, "_wr_first"}, first_wr - s_cyc, 3);
        check({t, "_wr_data"}, wr_bad, 0);
        check({t, "_rd_n"}, rd_cnt, 23);
        check({t, "_rd_first"}, first_rd - s_cyc, 30);
        check({t, "_rd_data"}, rd_bad, 0);
        check({t, "_done_at"}, done_cyc - s_cyc, 55);
        check({t, "_done_n"}, done_cnt, 1);
    endtask

    initial begin
        clr();
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_write", write, 0);
        check("rst_hxm_reset", hxm_reset, 0);
        check("rst_err", err_count, 0);
        reset = 1'b0;
        step();
        for (int i = 0; i < DEPTH; i++) load(i, 8'(8'h10 + 3 * i), 1'b1);

        // Test 1
        run_full("t1");
        check("t1_err", err_count, 0);
        check("t1_fev", first_err_valid, 0);

        // Test 2
        corrupt[ex_ssid[5]] = 1'b1;
        corrupt[ex_ssid[9]] = 1'b1;
        run_full("t2");
        check("t2_err", err_count, 2);
        check("t2_fev", first_err_valid, 1);
        check("t2_fei", first_err_idx, 5);
        corrupt[ex_ssid[5]] = 1'b0;
        corrupt[ex_ssid[9]] = 1'b0;

        // Test 3: empty run, then clamped write-only run with same-cycle load
        go(3'b110, 6'd0);
        check("t3_n0_wr", wr_cnt, 0);
        check("t3_n0_rd", rd_cnt, 0);
        check("t3_n0_done_at", done_cyc - s_cyc, 1);
        check("t3_n0_err_clr", err_count, 0);
        ex_ssid[0] = 8'hF0;
        ex_hit[0] = 8'hF0;
        load_en = 1'b1;
        load_idx = '0;
        load_ssid = 8'hF0;
        load_hitinfo = 8'hF0;
        load_chk = 1'b1;
        go(3'b010, 6'd40);
        check("t3_clamp_wr", wr_cnt, 32);
        check("t3_clamp_data", wr_bad, 0);
        check("t3_clamp_done_at", done_cyc - s_cyc, 33);

        // Test 4: abort on the 10th write
        clr();
        s_cyc = cyc;
        mode = 3'b111;
        n_entries = 6'd23;
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc - s_cyc < 12) step();
        check("t4_wr_pre", write, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_wr_post", write, 0);
        check("t4_busy_post", busy, 0);
        check("t4_wr_n", wr_cnt, 10);
        for (int i = 0; i < 60; i++) step();
        check("t4_no_done", done_cnt, 0);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("t4_abort_start", busy, 0);
        run_full("t4r");
        check("t4r_err", err_count, 0);

        // Test 5: unchecked entry, then saturation
        load(3, ex_ssid[3], 1'b0);
        corrupt[ex_ssid[3]] = 1'b1;
        corrupt[ex_ssid[7]] = 1'b1;
        run_full("t5");
        check("t5_err", err_count, 1);
        check("t5_fei", first_err_idx, 7);
        for (int i = 0; i < DEPTH; i++) corrupt[ex_ssid[i]] = 1'b1;
        go(3'b111, 6'd32);
        check("t5_sat_err", err_count, 15);
        check("t5_sat_fei", first_err_idx, 0);
        for (int i = 0; i < DEPTH; i++) corrupt[ex_ssid[i]] = 1'b0;
        load(3, ex_ssid[3], 1'b1);

        // Test 6: reset during READ, busy load ignored, then rerun
        corrupt[ex_ssid[0]] = 1'b1;
        clr();
        s_cyc = cyc;
        mode = 3'b111;
        n_entries = 6'd23;
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc - s_cyc < 5) step();
        load_en = 1'b1;
        load_idx = 5'd1;
        load_ssid = 8'hEE;
        load_hitinfo = 8'hEE;
        step();
        load_en = 1'b0;
        while (cyc - s_cyc < 35) step();
        check("t6_in_read", read, 1);
        check("t6_err_pre", err_count, 1);
        reset = 1'b1;
        step();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_read", read, 0);
        check("t6_rst_rssid", readSSID, 0);
        check("t6_rst_err", err_count, 0);
        check("t6_rst_fev", first_err_valid, 0);
        reset = 1'b0;
        corrupt[ex_ssid[0]] = 1'b0;
        step();
        run_full("t6r");
        check("t6r_err", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
